// File: rtl/tx_packet_arbiter_if.sv
// tx_packet_arbiter_if: concatenated per-port AXIS inputs plus the single shared AXIS output stream.
interface tx_packet_arbiter_if #(
  parameter int C_AXIS_DATA_WIDTH = 512,
  parameter int TUSER_WIDTH       = 1,
  parameter int TDEST_WIDTH       = 1,
  parameter int NUM_PORTS         = 4
);
  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]   S_AXIS_TDATA;
  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0] S_AXIS_TSTRB;
  logic [NUM_PORTS-1:0]                     S_AXIS_TLAST;
  logic [NUM_PORTS-1:0]                     S_AXIS_TVALID;
  logic [NUM_PORTS*TDEST_WIDTH-1:0]         S_AXIS_TDEST;
  logic [NUM_PORTS*TUSER_WIDTH-1:0]         S_AXIS_TUSER;
  logic [NUM_PORTS-1:0]                     S_AXIS_TREADY;
  logic [C_AXIS_DATA_WIDTH-1:0]             M_AXIS_TDATA;
  logic [C_AXIS_DATA_WIDTH/8-1:0]           M_AXIS_TSTRB;
  logic                                     M_AXIS_TLAST;
  logic                                     M_AXIS_TVALID;
  logic [TDEST_WIDTH-1:0]                   M_AXIS_TDEST;
  logic [TUSER_WIDTH-1:0]                   M_AXIS_TUSER;
  logic                                     M_AXIS_TREADY;
  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_TVALID, S_AXIS_TDEST, S_AXIS_TUSER, M_AXIS_TREADY,
    output S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_TVALID, M_AXIS_TDEST, M_AXIS_TUSER
  );
  modport master (
    output S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_TVALID, S_AXIS_TDEST, S_AXIS_TUSER, M_AXIS_TREADY,
    input  S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_TVALID, M_AXIS_TDEST, M_AXIS_TUSER
  );
endinterface

// File: rtl/tx_packet_arbiter.sv
// tx_packet_arbiter: packet-granular round-robin mux of NUM_PORTS AXIS sources onto one registered output.
module tx_packet_arbiter #(
  parameter int C_AXIS_DATA_WIDTH = 512,
  parameter int TUSER_WIDTH       = 1,
  parameter int TDEST_WIDTH       = 1,
  parameter int NUM_PORTS         = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  tx_packet_arbiter_if.slave           bus,
  output logic                         GRANT_VALID,
  output logic [$clog2(NUM_PORTS)-1:0] GRANT_IDX
);
  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int GW = $clog2(NUM_PORTS);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]             state_q, state_d;
  logic [GW-1:0]          g_q, g_d, ptr_q, ptr_d, sel, j;
  logic                   found, rdy, hs, eop;
  logic [DW-1:0]          tdata_q;
  logic [SW-1:0]          tstrb_q;
  logic                   tlast_q, tvalid_q;
  logic [TDEST_WIDTH-1:0] tdest_q;
  logic [TUSER_WIDTH-1:0] tuser_q;
  // Scanning from the far end lets the nearest requester after ptr overwrite the rest.
  always_comb begin
    sel = ptr_q;
    found = 1'b0;
    j = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      j = GW'((int'(ptr_q) + k) % NUM_PORTS);
      if (bus.S_AXIS_TVALID[j]) begin
        sel = j;
        found = 1'b1;
      end
    end
  end
  assign rdy = (state_q == BUSY) & (~tvalid_q | bus.M_AXIS_TREADY);
  assign hs  = rdy & bus.S_AXIS_TVALID[g_q];
  assign eop = hs & bus.S_AXIS_TLAST[g_q];
  assign state_d = (state_q == IDLE) ? (found ? BUSY : IDLE) : (eop ? IDLE : BUSY);
  assign g_d     = (state_q == IDLE && found) ? sel : g_q;
  assign ptr_d   = eop ? ((g_q == GW'(NUM_PORTS - 1)) ? '0 : g_q + GW'(1)) : ptr_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      g_q      <= '0;
      ptr_q    <= '0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      tdest_q  <= '0;
      tuser_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      if (hs) begin
        tdata_q  <= bus.S_AXIS_TDATA[g_q*DW +: DW];
        tstrb_q  <= bus.S_AXIS_TSTRB[g_q*SW +: SW];
        tlast_q  <= bus.S_AXIS_TLAST[g_q];
        tdest_q  <= bus.S_AXIS_TDEST[g_q*TDEST_WIDTH +: TDEST_WIDTH];
        tuser_q  <= bus.S_AXIS_TUSER[g_q*TUSER_WIDTH +: TUSER_WIDTH];
        tvalid_q <= 1'b1;
      end else if (bus.M_AXIS_TREADY) begin
        tvalid_q <= 1'b0;
      end
    end
  end
  assign bus.S_AXIS_TREADY = NUM_PORTS'(rdy) << g_q;
  assign bus.M_AXIS_TDATA  = tdata_q;
  assign bus.M_AXIS_TSTRB  = tstrb_q;
  assign bus.M_AXIS_TLAST  = tlast_q;
  assign bus.M_AXIS_TVALID = tvalid_q;
  assign bus.M_AXIS_TDEST  = tdest_q;
  assign bus.M_AXIS_TUSER  = tuser_q;
  assign GRANT_VALID = state_q == BUSY;
  assign GRANT_IDX   = g_q;
endmodule

// File: tb/tb_tx_packet_arbiter.sv
// tb_tx_packet_arbiter: directed scenarios with per-port source queues and an in-order output scoreboard.
module tb_tx_packet_arbiter;
  localparam int N  = 4;
  localparam int DW = 512;
  localparam int SW = DW / 8;
  localparam int UW = 1;
  localparam int TW = 1;
  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          l;
    logic [TW-1:0] t;
    logic [UW-1:0] u;
  } beat_t;
  logic CLK, RST, GRANT_VALID;
  logic [1:0] GRANT_IDX;
  logic [N-1:0] en, hs;
  bit chk_en;
  int tests, fails, n;
  beat_t src_q [N][$];
  beat_t exp_q [$];
  tx_packet_arbiter_if #(.C_AXIS_DATA_WIDTH(DW), .TUSER_WIDTH(UW), .TDEST_WIDTH(TW), .NUM_PORTS(N)) bus ();
  tx_packet_arbiter #(.C_AXIS_DATA_WIDTH(DW), .TUSER_WIDTH(UW), .TDEST_WIDTH(TW), .NUM_PORTS(N)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .GRANT_VALID(GRANT_VALID), .GRANT_IDX(GRANT_IDX)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  function automatic beat_t mk(int p, int k, bit l);
    beat_t b;
    b.d = {16{p[7:0], k[23:0]}};
    b.s = l ? ({SW{1'b1}} >> (8 * p)) : {SW{1'b1}};
    b.l = l;
    b.t = TW'(p);
    b.u = UW'(k);
    return b;
  endfunction
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(int c);
    repeat (c) @(posedge CLK);
    #3;
  endtask
  task automatic pkt(int p, int nb, int base, bit e = 1'b1);
    beat_t b;
    for (int k = 0; k < nb; k++) begin
      b = mk(p, base + k, k == nb - 1);
      src_q[p].push_back(b);
      if (e) exp_q.push_back(b);
    end
  endtask
  task automatic wait_valid();
    int c = 0;
    do begin cyc(1); c++; end while (!bus.M_AXIS_TVALID && c < 50);
    check("valid_timeout", 64'(bus.M_AXIS_TVALID), 64'd1);
  endtask
  task automatic wait_empty(output int c);
    c = 0;
    do begin cyc(1); c++; end while (exp_q.size() != 0 && c < 300);
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask
  task automatic do_reset();
    RST = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    cyc(2);
    RST = 1'b0;
  endtask
  // Handshakes are sampled mid-cycle; inputs are stable from +1 after an edge to the next edge.
  always @(negedge CLK) begin
    beat_t got, e;
    hs = bus.S_AXIS_TVALID & bus.S_AXIS_TREADY;
    if (!RST && chk_en && bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
      got = {bus.M_AXIS_TDATA, bus.M_AXIS_TSTRB, bus.M_AXIS_TLAST, bus.M_AXIS_TDEST, bus.M_AXIS_TUSER};
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL extra_beat: observed data %0h expected no beat", got.d[63:0]);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        assert (got === e) else begin
          fails++;
          $error("FAIL beat: observed %0h expected %0h", got, e);
        end
      end
    end
  end
  always @(posedge CLK) begin
    beat_t cur;
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      cur = (src_q[i].size() > 0) ? src_q[i][0] : '0;
      bus.S_AXIS_TVALID[i] = en[i] && src_q[i].size() > 0;
      bus.S_AXIS_TDATA[i*DW +: DW] = cur.d;
      bus.S_AXIS_TSTRB[i*SW +: SW] = cur.s;
      bus.S_AXIS_TLAST[i] = cur.l;
      bus.S_AXIS_TDEST[i*TW +: TW] = cur.t;
      bus.S_AXIS_TUSER[i*UW +: UW] = cur.u;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    beat_t b0;
    tests = 0;
    fails = 0;
    chk_en = 1'b1;
    hs = '0;
    en = '1;
    RST = 1'b1;
    bus.M_AXIS_TREADY = 1'b1;
    bus.S_AXIS_TVALID = '0;
    bus.S_AXIS_TDATA = '0;
    bus.S_AXIS_TSTRB = '0;
    bus.S_AXIS_TLAST = '0;
    bus.S_AXIS_TDEST = '0;
    bus.S_AXIS_TUSER = '0;
    cyc(2);
    check("rst_tready", 64'(bus.S_AXIS_TREADY), 64'd0);
    check("rst_mvalid", 64'(bus.M_AXIS_TVALID), 64'd0);
    check("rst_mlast", 64'(bus.M_AXIS_TLAST), 64'd0);
    check("rst_mdata", bus.M_AXIS_TDATA[63:0], 64'd0);
    check("rst_mstrb", bus.M_AXIS_TSTRB, 64'd0);
    check("rst_gvalid", 64'(GRANT_VALID), 64'd0);
    check("rst_gidx", 64'(GRANT_IDX), 64'd0);
    RST = 1'b0;
    pkt(2, 3, 0);
    cyc(1);
    check("idle_tready", 64'(bus.S_AXIS_TREADY), 64'd0);
    check("idle_gvalid", 64'(GRANT_VALID), 64'd0);
    cyc(1);
    check("c1_gvalid", 64'(GRANT_VALID), 64'd1);
    check("c1_gidx", 64'(GRANT_IDX), 64'd2);
    check("c1_tready", 64'(bus.S_AXIS_TREADY), 64'h4);
    check("c1_mvalid", 64'(bus.M_AXIS_TVALID), 64'd0);
    cyc(1);
    check("c2_mvalid", 64'(bus.M_AXIS_TVALID), 64'd1);
    check("c2_mlast", 64'(bus.M_AXIS_TLAST), 64'd0);
    cyc(1);
    check("c3_mvalid", 64'(bus.M_AXIS_TVALID), 64'd1);
    check("c3_mlast", 64'(bus.M_AXIS_TLAST), 64'd0);
    cyc(1);
    check("c4_mvalid", 64'(bus.M_AXIS_TVALID), 64'd1);
    check("c4_mlast", 64'(bus.M_AXIS_TLAST), 64'd1);
    check("c4_gvalid", 64'(GRANT_VALID), 64'd0);
    cyc(1);
    b0 = mk(2, 2, 1'b1);
    check("c5_mvalid", 64'(bus.M_AXIS_TVALID), 64'd0);
    check("c5_hold_data", bus.M_AXIS_TDATA[63:0], b0.d[63:0]);
    pkt(3, 2, 10);
    pkt(1, 1, 20);
    cyc(2);
    check("wrap_gidx", 64'(GRANT_IDX), 64'd3);
    wait_empty(n);
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < N; p++) pkt(p, 1, 100 + r);
    wait_empty(n);
    check("fair_cycles", 64'(n), 64'd26);
    pkt(1, 4, 40);
    wait_valid();
    bus.M_AXIS_TREADY = 1'b0;
    b0 = mk(1, 40, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("bp_mvalid", 64'(bus.M_AXIS_TVALID), 64'd1);
      check("bp_mdata", bus.M_AXIS_TDATA[63:0], b0.d[63:0]);
      check("bp_tready", 64'(bus.S_AXIS_TREADY), 64'd0);
    end
    bus.M_AXIS_TREADY = 1'b1;
    wait_empty(n);
    pkt(2, 3, 60);
    pkt(0, 1, 70);
    wait_valid();
    en[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("gap_tready0", 64'(bus.S_AXIS_TREADY[0]), 64'd0);
      check("gap_gidx", 64'(GRANT_IDX), 64'd2);
      check("gap_gvalid", 64'(GRANT_VALID), 64'd1);
    end
    en[2] = 1'b1;
    wait_empty(n);
    chk_en = 1'b0;
    pkt(3, 4, 80, 1'b0);
    wait_valid();
    RST = 1'b1;
    #1;
    check("mrst_mvalid", 64'(bus.M_AXIS_TVALID), 64'd0);
    check("mrst_tready", 64'(bus.S_AXIS_TREADY), 64'd0);
    check("mrst_gvalid", 64'(GRANT_VALID), 64'd0);
    check("mrst_mlast", 64'(bus.M_AXIS_TLAST), 64'd0);
    src_q[3].delete();
    cyc(1);
    RST = 1'b0;
    chk_en = 1'b1;
    pkt(0, 1, 90);
    pkt(3, 1, 91);
    cyc(2);
    check("mrst_gidx", 64'(GRANT_IDX), 64'd0);
    wait_empty(n);
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
